wired_bpu_fetchgen: RTL and testbench
=====================================

Name: wired_bpu_fetchgen

Overview:
- Parametrised successor of the two-slot PC generator: a fetch-block PC generator with a next-fetch predictor.
- Covers FETCH_WIDTH slots per block, with a configurable BTB, PHT and RAS depth.
- Adds global history, RAS repair on redirect, and reset-clearable BTB valid bits.
- Sits at the head of the frontend. It drives fetch-block PC, slot mask and per-slot prediction metadata to the I-cache stage, and takes updates and redirects from the backend.

Parameters:
FETCH_WIDTH, 2, instructions per fetch block; power of two, 1..8
BTB_DEPTH, 128, BTB entries per slot bank; power of two
TAG_W, 7, BTB tag bits
PHT_DEPTH, 256, 2-bit counters; power of two
GHR_W, 8, global history bits; GHR_W <= log2(PHT_DEPTH)
RAS_DEPTH, 8, return stack entries; power of two
RESET_PC, 32'h1c000000, PC after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
f_ready_i  in  1  fetch stage accepts block
f_valid_o  out  1  block valid
f_pc_o  out  32  current fetch PC
f_mask_o  out  FETCH_WIDTH  slot valid mask
f_taken_o  out  FETCH_WIDTH  one-hot predicted-taken slot, 0 if none
f_npc_o  out  32  predicted next PC
f_cnt_o  out  2*FETCH_WIDTH  PHT counter per slot
f_ghr_o  out  GHR_W  GHR used for this block
f_ras_ptr_o  out  log2(RAS_DEPTH)  RAS pointer before this block
upd_valid_i  in  1  training update
upd_pc_i  in  32  branch PC
upd_type_i  in  2  0 NPC, 1 IMM, 2 CALL, 3 RETURN
upd_cond_i  in  1  conditional branch
upd_taken_i  in  1  resolved direction
upd_target_i  in  32  resolved target
upd_cnt_i  in  2  counter value carried with the prediction
upd_ghr_i  in  GHR_W  GHR carried with the prediction
redir_valid_i  in  1  redirect
redir_pc_i  in  32  redirect target
redir_ghr_i  in  GHR_W  repaired GHR
redir_ras_ptr_i  in  log2(RAS_DEPTH)  repaired RAS pointer
redir_ras_we_i  in  1  repair RAS top entry
redir_ras_data_i  in  32  return address written at redir_ras_ptr_i

Behaviour:
Block geometry and reset
- OFF = log2(FETCH_WIDTH)+2.
- Slot i address = {pc[31:OFF], i, 2'b00}.
- f_mask_o[i] = (i >= pc[OFF-1:2]).
- Reset: pc=RESET_PC, ghr=0, ras_ptr=0, all BTB valid=0, all PHT counters=2'b01, f_valid_o=0.

Prediction (combinational from the registered pc)
- BTB bank i is indexed by pc[OFF+log2(BTB_DEPTH)-1:OFF]; tag = next TAG_W bits.
- Slot i hits when: mask[i], entry valid, tag match, and (type!=IMM || !cond || cnt[1]).
- The lowest hitting slot is taken.
- npc = RAS[ras_ptr] for RETURN, otherwise the BTB target; with no hit, npc = {pc[31:OFF]+1, OFF'b0}.
- PHT index = pc[OFF+log2(PHT_DEPTH)-1:OFF], combined with the GHR as described under Optional Feature.

Handshake and state update
- f_valid_o = !rst && !redir_valid_i. Fire = f_valid_o && f_ready_i.
- On fire:
  - pc <= npc.
  - GHR shifts left by one, inserting the taken bit, only if any masked slot at or before the taken slot (or any masked slot, when nothing is taken) is a conditional hit-candidate.
  - Taken CALL: ras_ptr+1, RAS[ras_ptr+1] <= slot address + 4.
  - Taken RETURN: ras_ptr-1.
- Pointer arithmetic wraps modulo RAS_DEPTH. Overflow silently overwrites the oldest entry; underflow wraps.
- Without fire, pc, GHR and RAS hold.

Redirect
- Priority over fire: pc<=redir_pc_i, ghr<=redir_ghr_i, ras_ptr<=redir_ras_ptr_i.
- If redir_ras_we_i: RAS[redir_ras_ptr_i] <= redir_ras_data_i.
- A same-cycle call push is dropped.

Training update (upd_valid_i)
- BTB bank upd_pc_i[OFF-1:2] at upd_pc index:
  - upd_type_i!=NPC: write {valid=1, type, cond, tag, target[31:2]}.
  - upd_type_i==NPC: clear valid.
- upd_cond_i: PHT[index(upd_pc_i, upd_ghr_i)] <= saturating counter of upd_cnt_i toward upd_taken_i (00..11).
- Update and read of the same entry in one cycle: the read sees the old value and the new value is visible next cycle.

Reset mid-operation
- rst overrides redirect and update. Everything returns to its reset state next cycle.

Optional Feature:
WIRED_BPU_GSHARE_EN
- Defined: PHT index low GHR_W bits are XORed with the GHR, for both prediction (current ghr) and update (upd_ghr_i).
- Undefined: PHT index uses PC bits only. The GHR is still maintained and output so the interface is unchanged.

Test Plan:
- Reset, f_ready_i=1, FETCH_WIDTH=2, no updates -> f_pc_o = 1c000000, 1c000008, 1c000010; f_mask_o=2'b11; f_taken_o=0.
- redir_pc_i=1c000104 -> next cycle f_pc_o=1c000104, f_mask_o=2'b10, f_valid_o=0 during the redirect cycle.
- Update unconditional IMM at 1c000020 with target 1c000400, then refetch 1c000020 -> f_taken_o=2'b01, f_npc_o=1c000400, f_mask_o=2'b11.
- CALL at 1c000044 to 1c000800, then RETURN at 1c000800 -> f_npc_o=1c000048; ras_ptr returns to 0. Nine nested calls with RAS_DEPTH=8 -> wrap, oldest overwritten.
- Conditional at 1c000060 with upd_cnt_i=01, upd_taken_i=1 -> counter 10, predicted taken next fetch. Four not-taken updates -> 00, saturate, not taken.
- Redirect and training update to the same BTB entry in the same cycle as fire -> redirect wins pc; the entry is visible on the second fetch of that block, not the first.

Source files
------------

// File: rtl/wired_bpu_fetchgen.sv
// Fetch-block PC generator with BTB/PHT/RAS next-fetch prediction.
// Define WIRED_BPU_GSHARE_EN to hash the global history into the PHT index.
module wired_bpu_fetchgen #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          BTB_DEPTH   = 128,
  parameter int          TAG_W       = 7,
  parameter int          PHT_DEPTH   = 256,
  parameter int          GHR_W       = 8,
  parameter int          RAS_DEPTH   = 8,
  parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_ready_i,
  output logic                       f_valid_o,
  output logic [31:0]                f_pc_o,
  output logic [FETCH_WIDTH-1:0]     f_mask_o,
  output logic [FETCH_WIDTH-1:0]     f_taken_o,
  output logic [31:0]                f_npc_o,
  output logic [2*FETCH_WIDTH-1:0]   f_cnt_o,
  output logic [GHR_W-1:0]           f_ghr_o,
  output logic [$clog2(RAS_DEPTH)-1:0] f_ras_ptr_o,
  input  logic                       upd_valid_i,
  input  logic [31:0]                upd_pc_i,
  input  logic [1:0]                 upd_type_i,
  input  logic                       upd_cond_i,
  input  logic                       upd_taken_i,
  input  logic [31:0]                upd_target_i,
  input  logic [1:0]                 upd_cnt_i,
  input  logic [GHR_W-1:0]           upd_ghr_i,
  input  logic                       redir_valid_i,
  input  logic [31:0]                redir_pc_i,
  input  logic [GHR_W-1:0]           redir_ghr_i,
  input  logic [$clog2(RAS_DEPTH)-1:0] redir_ras_ptr_i,
  input  logic                       redir_ras_we_i,
  input  logic [31:0]                redir_ras_data_i
);

  localparam int SW  = $clog2(FETCH_WIDTH);
  localparam int SWI = (SW > 0) ? SW : 1;
  localparam int OFF = SW + 2;
  localparam int BI  = $clog2(BTB_DEPTH);
  localparam int PI  = $clog2(PHT_DEPTH);
  localparam int RW  = $clog2(RAS_DEPTH);

  localparam logic [1:0] T_NPC  = 2'd0;
  localparam logic [1:0] T_IMM  = 2'd1;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  typedef struct packed {
    logic             v;
    logic [1:0]       ty;
    logic             cond;
    logic [TAG_W-1:0] tag;
    logic [29:0]      tgt;
  } btb_t;

  btb_t        btb_q [FETCH_WIDTH][BTB_DEPTH];
  logic [1:0]  pht_q [PHT_DEPTH];
  logic [31:0] ras_q [RAS_DEPTH];

  logic [31:0]      pc_q, pc_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [RW-1:0]    ras_ptr_q, ras_ptr_d;

  logic [SWI-1:0]         cur_off, tsel;
  logic [BI-1:0]          rd_idx;
  logic [TAG_W-1:0]       rd_tag;
  logic [PI-1:0]          rd_pi;
  logic [1:0]             cnt_rd;
  logic [FETCH_WIDTH-1:0] mask, hit, ccand, taken;
  logic                   found, ghr_en, fire;
  btb_t                   te;
  logic [31:0]            blk_base, slot_addr, npc;

  logic          ras_we;
  logic [RW-1:0] ras_wa;
  logic [31:0]   ras_wd;

  logic [SWI-1:0]   upd_bank;
  logic [BI-1:0]    upd_idx;
  logic [PI-1:0]    wr_pi;
  logic [1:0]       cnt_nx;
  btb_t             btb_w;

  logic unused_bits;
  assign unused_bits = ^{pc_q[1:0], upd_pc_i, upd_target_i[1:0],
                         upd_ghr_i, ghr_q};

  // Prediction from the registered fetch PC
  always_comb begin
    cur_off = '0;
    if (SW > 0) cur_off = pc_q[2 +: SWI];
    rd_idx = pc_q[OFF +: BI];
    rd_tag = pc_q[OFF+BI +: TAG_W];
    rd_pi  = pc_q[OFF +: PI];
`ifdef WIRED_BPU_GSHARE_EN
    rd_pi[GHR_W-1:0] = rd_pi[GHR_W-1:0] ^ ghr_q;
`endif
    cnt_rd = pht_q[rd_pi];
    mask   = '0;
    hit    = '0;
    ccand  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      btb_t e;
      logic cand;
      e        = btb_q[i][rd_idx];
      mask[i]  = (i >= int'(cur_off));
      cand     = mask[i] && e.v && (e.tag == rd_tag);
      ccand[i] = cand && (e.ty == T_IMM) && e.cond;
      hit[i]   = cand && ((e.ty != T_IMM) || !e.cond || cnt_rd[1]);
    end
    found = 1'b0;
    tsel  = '0;
    for (int i = FETCH_WIDTH-1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        tsel  = SWI'(i);
      end
    end
    ghr_en = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (ccand[i] && (!found || i <= int'(tsel))) ghr_en = 1'b1;
    end
    te        = btb_q[tsel][rd_idx];
    taken     = found ? (FETCH_WIDTH'(1) << tsel) : '0;
    blk_base  = {pc_q[31:OFF], OFF'(0)};
    slot_addr = blk_base | (32'(tsel) << 2);
    npc       = blk_base + 32'(FETCH_WIDTH * 4);
    if (found) begin
      npc = (te.ty == T_RET) ? ras_q[ras_ptr_q] : {te.tgt, 2'b00};
    end
  end

  assign f_valid_o   = !rst && !redir_valid_i;
  assign fire        = f_valid_o && f_ready_i;
  assign f_pc_o      = pc_q;
  assign f_mask_o    = mask;
  assign f_taken_o   = taken;
  assign f_npc_o     = npc;
  assign f_cnt_o     = {FETCH_WIDTH{cnt_rd}};
  assign f_ghr_o     = ghr_q;
  assign f_ras_ptr_o = ras_ptr_q;

  always_comb begin
    pc_d      = pc_q;
    ghr_d     = ghr_q;
    ras_ptr_d = ras_ptr_q;
    ras_we    = 1'b0;
    ras_wa    = ras_ptr_q;
    ras_wd    = slot_addr + 32'd4;
    if (redir_valid_i) begin
      pc_d      = redir_pc_i;
      ghr_d     = redir_ghr_i;
      ras_ptr_d = redir_ras_ptr_i;
      ras_we    = redir_ras_we_i;
      ras_wa    = redir_ras_ptr_i;
      ras_wd    = redir_ras_data_i;
    end else if (fire) begin
      pc_d = npc;
      if (ghr_en) ghr_d = (ghr_q << 1) | GHR_W'(found);
      if (found && te.ty == T_CALL) begin
        ras_ptr_d = ras_ptr_q + 1'b1;
        ras_we    = 1'b1;
        ras_wa    = ras_ptr_q + 1'b1;
      end else if (found && te.ty == T_RET) begin
        ras_ptr_d = ras_ptr_q - 1'b1;
      end
    end
  end

  // Training path
  always_comb begin
    upd_bank = '0;
    if (SW > 0) upd_bank = upd_pc_i[2 +: SWI];
    upd_idx = upd_pc_i[OFF +: BI];
    wr_pi   = upd_pc_i[OFF +: PI];
`ifdef WIRED_BPU_GSHARE_EN
    wr_pi[GHR_W-1:0] = wr_pi[GHR_W-1:0] ^ upd_ghr_i;
`endif
    if (upd_taken_i) cnt_nx = (upd_cnt_i == 2'b11) ? 2'b11 : upd_cnt_i + 2'b01;
    else             cnt_nx = (upd_cnt_i == 2'b00) ? 2'b00 : upd_cnt_i - 2'b01;
    btb_w.v    = (upd_type_i != T_NPC);
    btb_w.ty   = upd_type_i;
    btb_w.cond = upd_cond_i;
    btb_w.tag  = upd_pc_i[OFF+BI +: TAG_W];
    btb_w.tgt  = upd_target_i[31:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ghr_q     <= '0;
      ras_ptr_q <= '0;
      for (int i = 0; i < FETCH_WIDTH; i++)
        for (int j = 0; j < BTB_DEPTH; j++)
          btb_q[i][j] <= '0;
      for (int k = 0; k < PHT_DEPTH; k++) pht_q[k] <= 2'b01;
    end else begin
      pc_q      <= pc_d;
      ghr_q     <= ghr_d;
      ras_ptr_q <= ras_ptr_d;
      if (ras_we) ras_q[ras_wa] <= ras_wd;
      if (upd_valid_i) btb_q[upd_bank][upd_idx] <= btb_w;
      if (upd_valid_i && upd_cond_i) pht_q[wr_pi] <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_wired_bpu_fetchgen.sv
// Scoreboard bench for wired_bpu_fetchgen (FETCH_WIDTH=2, default build).
// Expected blocks are queued as stimulus is driven and popped on each fire.
module tb_wired_bpu_fetchgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_ready_i;
  logic        f_valid_o;
  logic [31:0] f_pc_o;
  logic [1:0]  f_mask_o;
  logic [1:0]  f_taken_o;
  logic [31:0] f_npc_o;
  logic [3:0]  f_cnt_o;
  logic [7:0]  f_ghr_o;
  logic [2:0]  f_ras_ptr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [1:0]  upd_type_i;
  logic        upd_cond_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic [1:0]  upd_cnt_i;
  logic [7:0]  upd_ghr_i;
  logic        redir_valid_i;
  logic [31:0] redir_pc_i;
  logic [7:0]  redir_ghr_i;
  logic [2:0]  redir_ras_ptr_i;
  logic        redir_ras_we_i;
  logic [31:0] redir_ras_data_i;

  wired_bpu_fetchgen dut (
    .clk(clk), .rst(rst), .f_ready_i(f_ready_i),
    .f_valid_o(f_valid_o), .f_pc_o(f_pc_o), .f_mask_o(f_mask_o),
    .f_taken_o(f_taken_o), .f_npc_o(f_npc_o), .f_cnt_o(f_cnt_o),
    .f_ghr_o(f_ghr_o), .f_ras_ptr_o(f_ras_ptr_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_type_i(upd_type_i), .upd_cond_i(upd_cond_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_cnt_i(upd_cnt_i), .upd_ghr_i(upd_ghr_i),
    .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
    .redir_ghr_i(redir_ghr_i), .redir_ras_ptr_i(redir_ras_ptr_i),
    .redir_ras_we_i(redir_ras_we_i), .redir_ras_data_i(redir_ras_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [1:0]  taken;
    logic [31:0] npc;
    logic [7:0]  ghr;
    logic [2:0]  ptr;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && f_valid_o && f_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexp_fire", f_pc_o, 32'hffffffff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pc",    f_pc_o,             mon_e.pc);
        chk("mask",  32'(f_mask_o),      32'(mon_e.mask));
        chk("taken", 32'(f_taken_o),     32'(mon_e.taken));
        chk("npc",   f_npc_o,            mon_e.npc);
        chk("ghr",   32'(f_ghr_o),       32'(mon_e.ghr));
        chk("ptr",   32'(f_ras_ptr_o),   32'(mon_e.ptr));
        chk("cnt",   32'(f_cnt_o),       32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_exp(input logic [31:0] pc, input logic [1:0] mask,
                           input logic [1:0] tk, input logic [31:0] npc,
                           input logic [7:0] ghr, input logic [2:0] ptr,
                           input logic [3:0] cnt = 4'b0101);
    exp_t e;
    e.pc = pc; e.mask = mask; e.taken = tk; e.npc = npc;
    e.ghr = ghr; e.ptr = ptr; e.cnt = cnt;
    exp_q.push_back(e);
    f_ready_i = 1'b1;
    tick();
  endtask

  task automatic redirect(input logic [31:0] pc, input logic [7:0] ghr,
                          input logic [2:0] ptr, input logic we = 1'b0,
                          input logic [31:0] data = 32'h0);
    redir_valid_i    = 1'b1;
    redir_pc_i       = pc;
    redir_ghr_i      = ghr;
    redir_ras_ptr_i  = ptr;
    redir_ras_we_i   = we;
    redir_ras_data_i = data;
    @(negedge clk);
    chk("redir_vld", 32'(f_valid_o), 32'd0);
    tick();
    redir_valid_i  = 1'b0;
    redir_ras_we_i = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [1:0] ty,
                         input logic cond, input logic tk,
                         input logic [31:0] tgt, input logic [1:0] cnt);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_type_i   = ty;
    upd_cond_i   = cond;
    upd_taken_i  = tk;
    upd_target_i = tgt;
    upd_cnt_i    = cnt;
    upd_ghr_i    = 8'h00;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [1:0] ty,
                        input logic cond, input logic tk,
                        input logic [31:0] tgt, input logic [1:0] cnt);
    f_ready_i = 1'b0;
    set_upd(pc, ty, cond, tk, tgt, cnt);
    tick();
    upd_valid_i = 1'b0;
  endtask

  logic [31:0] ck, cn, rpc;
  logic [1:0]  m;

  initial begin
    rst = 1'b1; f_ready_i = 1'b1;
    upd_valid_i = 0; upd_pc_i = 0; upd_type_i = 0; upd_cond_i = 0;
    upd_taken_i = 0; upd_target_i = 0; upd_cnt_i = 0; upd_ghr_i = 0;
    redir_valid_i = 0; redir_pc_i = 0; redir_ghr_i = 0;
    redir_ras_ptr_i = 0; redir_ras_we_i = 0; redir_ras_data_i = 0;
    tick();
    @(negedge clk);
    chk("rst_vld", 32'(f_valid_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_pc",  f_pc_o, 32'h1c000000);
    chk("rst_ghr", 32'(f_ghr_o), 32'd0);
    chk("rst_ptr", 32'(f_ras_ptr_o), 32'd0);
    chk("rst_vld1", 32'(f_valid_o), 32'd1);

    // sequential fetch
    fetch_exp(32'h1c000000, 2'b11, 2'b00, 32'h1c000008, 8'h0, 3'd0);
    fetch_exp(32'h1c000008, 2'b11, 2'b00, 32'h1c000010, 8'h0, 3'd0);
    fetch_exp(32'h1c000010, 2'b11, 2'b00, 32'h1c000018, 8'h0, 3'd0);

    // redirect into the middle of a block
    redirect(32'h1c000104, 8'h0, 3'd0);
    fetch_exp(32'h1c000104, 2'b10, 2'b00, 32'h1c000108, 8'h0, 3'd0);

    // unconditional jump
    do_upd(32'h1c000020, 2'd1, 1'b0, 1'b1, 32'h1c000400, 2'b01);
    redirect(32'h1c000020, 8'h0, 3'd0);
    fetch_exp(32'h1c000020, 2'b11, 2'b01, 32'h1c000400, 8'h0, 3'd0);
    fetch_exp(32'h1c000400, 2'b11, 2'b00, 32'h1c000408, 8'h0, 3'd0);

    // call then return
    do_upd(32'h1c000044, 2'd2, 1'b0, 1'b1, 32'h1c000800, 2'b01);
    do_upd(32'h1c000800, 2'd3, 1'b0, 1'b1, 32'h00000000, 2'b01);
    redirect(32'h1c000040, 8'h0, 3'd0);
    fetch_exp(32'h1c000040, 2'b11, 2'b10, 32'h1c000800, 8'h0, 3'd0);
    fetch_exp(32'h1c000800, 2'b11, 2'b01, 32'h1c000048, 8'h0, 3'd1);
    fetch_exp(32'h1c000048, 2'b11, 2'b00, 32'h1c000050, 8'h0, 3'd0);

    // nine chained calls wrap the 8-entry stack
    rpc = 32'h1c002000;
    for (int k = 0; k < 9; k++) begin
      ck = 32'h1c001010 + 32'(16 * k);
      cn = (k < 8) ? ck + 32'd16 : rpc;
      do_upd(ck, 2'd2, 1'b0, 1'b1, cn, 2'b01);
    end
    do_upd(rpc, 2'd3, 1'b0, 1'b1, 32'h0, 2'b01);
    redirect(32'h1c001010, 8'h0, 3'd0);
    for (int k = 0; k < 9; k++) begin
      ck = 32'h1c001010 + 32'(16 * k);
      cn = (k < 8) ? ck + 32'd16 : rpc;
      fetch_exp(ck, 2'b11, 2'b01, cn, 8'h0, 3'(k));
    end
    fetch_exp(rpc, 2'b11, 2'b01, 32'h1c001094, 8'h0, 3'd1);
    fetch_exp(32'h1c001094, 2'b10, 2'b00, 32'h1c001098, 8'h0, 3'd0);

    // RAS repair on redirect
    redirect(rpc, 8'h0, 3'd3, 1'b1, 32'h1c00abc0);
    fetch_exp(rpc, 2'b11, 2'b01, 32'h1c00abc0, 8'h0, 3'd3);
    fetch_exp(32'h1c00abc0, 2'b11, 2'b00, 32'h1c00abc8, 8'h0, 3'd2);

    // conditional branch training and saturation
    m = 2'b01;
    do_upd(32'h1c000060, 2'd1, 1'b1, 1'b1, 32'h1c000300, m);
    m = 2'b10;
    redirect(32'h1c000060, 8'h0, 3'd0);
    fetch_exp(32'h1c000060, 2'b11, 2'b01, 32'h1c000300, 8'h0, 3'd0, 4'b1010);
    fetch_exp(32'h1c000300, 2'b11, 2'b00, 32'h1c000308, 8'h1, 3'd0);
    for (int k = 0; k < 4; k++) begin
      do_upd(32'h1c000060, 2'd1, 1'b1, 1'b0, 32'h1c000300, m);
      m = (m == 2'b00) ? 2'b00 : m - 2'b01;
    end
    redirect(32'h1c000060, 8'h05, 3'd0);
    fetch_exp(32'h1c000060, 2'b11, 2'b00, 32'h1c000068, 8'h05, 3'd0,
              {m, m});
    fetch_exp(32'h1c000068, 2'b11, 2'b00, 32'h1c000070, 8'h0a, 3'd0);

    // update racing a read of the same entry
    redirect(32'h1c0000a0, 8'h0, 3'd0);
    set_upd(32'h1c0000a0, 2'd1, 1'b0, 1'b1, 32'h1c000500, 2'b01);
    fetch_exp(32'h1c0000a0, 2'b11, 2'b00, 32'h1c0000a8, 8'h0, 3'd0);
    set_upd(32'h1c0000a0, 2'd1, 1'b0, 1'b1, 32'h1c000600, 2'b01);
    redirect(32'h1c0000a0, 8'h0, 3'd0);
    upd_valid_i = 1'b0;
    fetch_exp(32'h1c0000a0, 2'b11, 2'b01, 32'h1c000600, 8'h0, 3'd0);
    fetch_exp(32'h1c000600, 2'b11, 2'b00, 32'h1c000608, 8'h0, 3'd0);

    // NPC-type update invalidates the entry
    do_upd(32'h1c0000a0, 2'd0, 1'b0, 1'b0, 32'h0, 2'b01);
    redirect(32'h1c0000a0, 8'h0, 3'd0);
    fetch_exp(32'h1c0000a0, 2'b11, 2'b00, 32'h1c0000a8, 8'h0, 3'd0);

    // reset overrides a concurrent redirect and update
    rst = 1'b1;
    redir_valid_i = 1'b1;
    redir_pc_i = 32'h1c000770;
    redir_ghr_i = 8'h33;
    redir_ras_ptr_i = 3'd5;
    set_upd(32'h1c000020, 2'd1, 1'b0, 1'b1, 32'h1c000900, 2'b01);
    tick();
    rst = 1'b0;
    redir_valid_i = 1'b0;
    upd_valid_i = 1'b0;
    #1;
    chk("mid_rst_pc",  f_pc_o, 32'h1c000000);
    chk("mid_rst_ghr", 32'(f_ghr_o), 32'd0);
    chk("mid_rst_ptr", 32'(f_ras_ptr_o), 32'd0);
    fetch_exp(32'h1c000000, 2'b11, 2'b00, 32'h1c000008, 8'h0, 3'd0);
    redirect(32'h1c000060, 8'h0, 3'd0);
    fetch_exp(32'h1c000060, 2'b11, 2'b00, 32'h1c000068, 8'h0, 3'd0);
    redirect(32'h1c000020, 8'h0, 3'd0);
    fetch_exp(32'h1c000020, 2'b11, 2'b00, 32'h1c000028, 8'h0, 3'd0);
    f_ready_i = 1'b0;
    tick();
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
